// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package mau_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Undefined funct3 encodings fall through to a word access.
  function automatic size_e acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: acc_size = SZ_B;
      F3_H, F3_HU: acc_size = SZ_H;
      default:     acc_size = SZ_W;
    endcase
  endfunction

  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (acc_size(f3))
      SZ_B:    eff_off = off;
      SZ_H:    eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (acc_size(f3))
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mau_align.sv
// Lane formatting: store replication/byte enables and load extract/extension.
module mau_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_f3_i,
  input  logic [1:0]        st_off_i,
  input  logic [DATA_W-1:0] st_wd_i,
  output logic [DATA_W-1:0] st_wdata_o,
  output logic [3:0]        st_be_o,
  input  logic [2:0]        ld_f3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [1:0]  st_off, ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_zext;

  always_comb begin
    st_off = eff_off(st_f3_i, st_off_i);
    case (acc_size(st_f3_i))
      SZ_B: begin
        st_wdata_o = {4{st_wd_i[7:0]}};
        st_be_o    = BE_BYTE << st_off;
      end
      SZ_H: begin
        st_wdata_o = {2{st_wd_i[15:0]}};
        st_be_o    = BE_HALF << st_off;
      end
      default: begin
        st_wdata_o = st_wd_i;
        st_be_o    = BE_WORD;
      end
    endcase
  end

  always_comb begin
    ld_off  = eff_off(ld_f3_i, ld_off_i);
    ld_zext = (ld_f3_i == F3_BU) || (ld_f3_i == F3_HU);
    ld_half = ld_off[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_off)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    case (acc_size(ld_f3_i))
      SZ_B:    ld_data_o = {{(DATA_W-8){ld_byte[7] & ~ld_zext}}, ld_byte};
      SZ_H:    ld_data_o = {{(DATA_W-16){ld_half[15] & ~ld_zext}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I M-stage load/store unit: req/gnt/rvalid data-memory handshake with pipeline stall.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misaligned_m.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic [DATA_W-1:0] read_data_m,
  output logic              stall_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
`ifdef MISALIGN_TRAP_EN
  output logic              misaligned_m,
`endif
  input  logic [DATA_W-1:0] dmem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [3:0]        st_be;
  logic              mem_op, accept, capture, mis;

  assign mem_op = mem_read_m | mem_write_m;
  assign accept = (state_q == S_IDLE) && mem_op;

  mau_align #(.DATA_W(DATA_W)) u_align (
    .st_f3_i   (funct3_m),
    .st_off_i  (alu_result_m[1:0]),
    .st_wd_i   (write_data_m),
    .st_wdata_o(st_wdata),
    .st_be_o   (st_be),
    .ld_f3_i   (f3_q),
    .ld_off_i  (off_q),
    .ld_rdata_i(dmem_rdata),
    .ld_data_o (ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign mis          = misaligned(funct3_m, alu_result_m[1:0]);
  assign misaligned_m = (state_q == S_DONE) && mis_q;
  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= mis;
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall_m = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (mem_op) begin
        stall_m = 1'b1;
        state_d = mis ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall_m = 1'b1;
        if (dmem_gnt) begin
          if (we_q) state_d = S_DONE;
          else if (dmem_rvalid) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        stall_m = 1'b1;
        if (dmem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {alu_result_m[ADDR_W-1:2], 2'b00};
        be_q    <= mis ? 4'b0000 : st_be;
        wdata_q <= st_wdata;
        we_q    <= mem_write_m;
        f3_q    <= funct3_m;
        off_q   <= alu_result_m[1:0];
      end
      // A trapped load never reaches the bus, so its result reads as zero.
      if (accept && mis && !mem_write_m) rdata_q <= '0;
      else if (capture)                  rdata_q <= ld_data;
    end
  end

  assign dmem_req    = (state_q == S_REQ);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign read_data_m = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with an inline req/gnt/rvalid memory responder.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m, read_data_m;
  logic        stall_m, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_m;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_m  (mem_read_m),
    .mem_write_m (mem_write_m),
    .funct3_m    (funct3_m),
    .alu_result_m(alu_result_m),
    .write_data_m(write_data_m),
    .read_data_m (read_data_m),
    .stall_m     (stall_m),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
`ifdef MISALIGN_TRAP_EN
    .misaligned_m(misaligned_m),
`endif
    .dmem_rdata  (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Starts on a negedge; returns on the negedge that begins the cycle after DONE.
  task automatic run_op(input string tag, input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int gnt_dly, input int rv_dly,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input int e_stalls, input logic [31:0] e_rd);
    exp_t e;
    int   stalls = 0, reqn = 0, wcnt = 0;
    bit   granted = 0, done = 0;
    e = '{tag, we, e_addr, e_wdata, e_be, e_stalls, e_rd};
    sb.push_back(e);
    mem_write_m  = we;
    mem_read_m   = re;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'hBAD0_BAD0;
      if (stall_m) stalls++;
      if (dmem_req) begin
        chk({sb[0].tag, ".addr"},  dmem_addr,  sb[0].addr);
        chk({sb[0].tag, ".be"},    {28'd0, dmem_be}, {28'd0, sb[0].be});
        chk({sb[0].tag, ".wdata"}, dmem_wdata, sb[0].wdata);
        chk({sb[0].tag, ".we"},    {31'd0, dmem_we}, {31'd0, sb[0].we});
        if (reqn == gnt_dly) begin
          dmem_gnt = 1'b1;
          granted  = 1;
          if (!we && rv_dly == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
          end
        end
        reqn++;
      end else if (granted && stall_m) begin
        wcnt++;
        if (wcnt == rv_dly) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rd;
        end
      end else if (cyc > 0 && !stall_m) begin
        done        = 1;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".stalls"}, stalls, e.stalls);
        chk({e.tag, ".rdata"},  read_data_m, e.rd);
      end
      @(negedge clk);
    end
    if (!done) begin
      chk({tag, ".timeout"}, 32'd1, 32'd0);
      void'(sb.pop_front());
      mem_read_m  = 1'b0;
      mem_write_m = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b0;
    alu_result_m = '0; write_data_m = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.read_data", read_data_m, 32'h0);
    chk("rst.req",   {31'd0, dmem_req}, 32'h0);
    chk("rst.we",    {31'd0, dmem_we},  32'h0);
    chk("rst.addr",  dmem_addr,  32'h0);
    chk("rst.be",    {28'd0, dmem_be}, 32'h0);
    chk("rst.wdata", dmem_wdata, 32'h0);
    chk("rst.stall", {31'd0, stall_m}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    //      tag      we re  f3      addr          wd            rd            g  r  e_addr        be       e_wdata       st rd
    run_op("sw",    1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 2, 32'h0);
    run_op("sb",    1, 0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        3, 0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 5, 32'h0);
    run_op("sh",    1, 0, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        1, 0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 3, 32'h0);
    run_op("lb",    0, 1, 3'b000, 32'h0000_0102, 32'h0,        32'h12F4_5678, 0, 0, 32'h0000_0100, 4'b0100, 32'h0,         2, 32'hFFFF_FFF4);
    run_op("lbu",   0, 1, 3'b100, 32'h0000_0102, 32'h0,        32'h12F4_5678, 0, 1, 32'h0000_0100, 4'b0100, 32'h0,         3, 32'h0000_00F4);
    run_op("lhu",   0, 1, 3'b101, 32'h0000_0102, 32'h0,        32'h12F4_5678, 2, 0, 32'h0000_0100, 4'b1100, 32'h0,         4, 32'h0000_12F4);
    run_op("lh",    0, 1, 3'b001, 32'h0000_0100, 32'h0,        32'h12F4_8765, 0, 1, 32'h0000_0100, 4'b0011, 32'h0,         3, 32'hFFFF_8765);
    run_op("lw",    0, 1, 3'b010, 32'h0000_0204, 32'h0,        32'hCAFE_F00D, 0, 1, 32'h0000_0204, 4'b1111, 32'h0,         3, 32'hCAFE_F00D);

    // Spurious response while idle must not disturb the last load result.
    #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    #1;
    dmem_rvalid = 1'b0;
    chk("idle_rvalid.rdata", read_data_m, 32'hCAFE_F00D);
    chk("idle_rvalid.stall", {31'd0, stall_m}, 32'h0);
    @(negedge clk);

    run_op("ld_st", 1, 1, 3'b010, 32'h0000_0108, 32'h0102_0304, 32'h0,        0, 0, 32'h0000_0108, 4'b1111, 32'h0102_0304, 2, 32'hCAFE_F00D);
    run_op("lb1",   0, 1, 3'b000, 32'h0000_0101, 32'h0,        32'h12F4_5678, 1, 2, 32'h0000_0100, 4'b0010, 32'h0,         5, 32'h0000_0056);
    run_op("f3_011",0, 1, 3'b011, 32'h0000_010C, 32'h0,        32'h89AB_CDEF, 0, 0, 32'h0000_010C, 4'b1111, 32'h0,         2, 32'h89AB_CDEF);

    // Reset while waiting for read data: the late response must be dropped.
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h0000_0200; write_data_m = '0;
    #1;
    @(negedge clk);
    #1;
    chk("rst_mid.req", {31'd0, dmem_req}, 32'h1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    #1;
    dmem_gnt   = 1'b0;
    mem_read_m = 1'b0;
    chk("rst_mid.wait_stall", {31'd0, stall_m}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    chk("rst_mid.stall", {31'd0, stall_m}, 32'h0);
    chk("rst_mid.rdata", read_data_m, 32'h0);
    @(negedge clk);
    #1;
    dmem_rvalid = 1'b0;
    chk("rst_mid.rdata_after", read_data_m, 32'h0);
    chk("rst_mid.req_after", {31'd0, dmem_req}, 32'h0);
    chk("rst_mid.stall_after", {31'd0, stall_m}, 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
